// File: rtl/uart_tx_framer.sv
// uart_tx_framer: transmit-side UART framer.
// Bytes enter through a valid/ready handshake into a small FIFO. Each byte is sent as
// one start bit, eight data bits (LSB first), one parity bit and two stop bits, with an
// optional run of idle-high gap bits after every frame. One bit per w_baud_clk cycle.

module uart_tx_framer #(
   parameter int p_fifo_depth = 4,
   parameter bit p_parity_odd = 1'b0,
   parameter int p_gap_bits   = 0
) (
   input  logic                          w_baud_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   input  logic [7:0]                    i_data,
   output logic                          o_ready,
   output logic                          o_tx,
   output logic                          o_busy,
   output logic [$clog2(p_fifo_depth):0] o_count
);

   localparam int          AW         = $clog2(p_fifo_depth);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(p_fifo_depth);
   localparam logic [3:0]  GAP_LOAD   = (p_gap_bits > 0) ? 4'(p_gap_bits - 1) : 4'd0;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP1  = 3'd4;
   localparam logic [2:0] S_STOP2  = 3'd5;
   localparam logic [2:0] S_GAP    = 3'd6;

   logic [7:0]    mem [p_fifo_depth];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic [2:0]    state;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          parity_bit;
   logic [3:0]    gap_cnt;
   logic          tx_reg;

   logic          push;
   logic          pop;
   logic [7:0]    head_byte;
   logic          head_parity;

   // A push is refused whenever the FIFO is full, even if a pop happens on the same edge.
   assign o_ready     = (count != FULL_COUNT);
   assign push        = i_valid & o_ready;
   assign head_byte   = mem[rd_ptr];
   assign head_parity = (^head_byte) ^ p_parity_odd;

   // The FSM pops only when it is about to start a new frame and a byte is waiting.
   always_comb begin
      pop = 1'b0;
      if (count != '0) begin
         case (state)
            S_IDLE:  pop = 1'b1;
            S_STOP2: pop = (p_gap_bits == 0);
            S_GAP:   pop = (gap_cnt == 4'd0);
            default: pop = 1'b0;
         endcase
      end
   end

   // FIFO storage; contents need no reset because the pointers define what is valid.
   always_ff @(posedge w_baud_clk) begin
      if (push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge w_baud_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Frame sequencer; the line level is registered together with the state it belongs to.
   always_ff @(posedge w_baud_clk or negedge i_rst) begin
      if (!i_rst) begin
         state      <= S_IDLE;
         bit_idx    <= 3'd0;
         shift_reg  <= 8'd0;
         parity_bit <= 1'b0;
         gap_cnt    <= 4'd0;
         tx_reg     <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               tx_reg <= 1'b1;
               if (pop) begin
                  shift_reg  <= head_byte;
                  parity_bit <= head_parity;
                  state      <= S_START;
                  tx_reg     <= 1'b0;
               end
            end
            S_START: begin
               state   <= S_DATA;
               bit_idx <= 3'd0;
               tx_reg  <= shift_reg[0];
            end
            S_DATA: begin
               if (bit_idx == 3'd7) begin
                  state  <= S_PARITY;
                  tx_reg <= parity_bit;
               end else begin
                  bit_idx <= bit_idx + 3'd1;
                  tx_reg  <= shift_reg[bit_idx + 3'd1];
               end
            end
            S_PARITY: begin
               state  <= S_STOP1;
               tx_reg <= 1'b1;
            end
            S_STOP1: begin
               state  <= S_STOP2;
               tx_reg <= 1'b1;
            end
            S_STOP2: begin
               if (p_gap_bits > 0) begin
                  state   <= S_GAP;
                  gap_cnt <= GAP_LOAD;
                  tx_reg  <= 1'b1;
               end else if (pop) begin
                  shift_reg  <= head_byte;
                  parity_bit <= head_parity;
                  state      <= S_START;
                  tx_reg     <= 1'b0;
               end else begin
                  state  <= S_IDLE;
                  tx_reg <= 1'b1;
               end
            end
            S_GAP: begin
               if (gap_cnt == 4'd0) begin
                  if (pop) begin
                     shift_reg  <= head_byte;
                     parity_bit <= head_parity;
                     state      <= S_START;
                     tx_reg     <= 1'b0;
                  end else begin
                     state  <= S_IDLE;
                     tx_reg <= 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
                  tx_reg  <= 1'b1;
               end
            end
            default: begin
               state  <= S_IDLE;
               tx_reg <= 1'b1;
            end
         endcase
      end
   end

   assign o_tx    = tx_reg;
   assign o_busy  = (state != S_IDLE);
   assign o_count = count;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: self-checking bench for uart_tx_framer.
// Two instances: one with default parameters, one with odd parity and a 3-bit gap.
// The reference model keeps a byte queue and a queue of line bits still to be sent.

module tb_uart_tx_framer;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       valid_a = 1'b0, valid_b = 1'b0;
   logic [7:0] data_a = 8'd0, data_b = 8'd0;
   logic       ready_a, tx_a, busy_a;
   logic       ready_b, tx_b, busy_b;
   logic [2:0] count_a, count_b;

   bit         sel = 1'b0;
   int         tests = 0;
   int         fails = 0;

   logic [7:0] mq[$];
   bit         lq[$];
   int         m_odd = 0;
   int         m_gap = 0;
   bit         last_push = 1'b0;
   logic [11:0] cap = 12'd0;

   uart_tx_framer #(.p_fifo_depth(DEPTH), .p_parity_odd(1'b0), .p_gap_bits(0)) dut_a (
      .w_baud_clk(clk), .i_rst(rst), .i_valid(valid_a), .i_data(data_a),
      .o_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a), .o_count(count_a)
   );

   uart_tx_framer #(.p_fifo_depth(DEPTH), .p_parity_odd(1'b1), .p_gap_bits(3)) dut_b (
      .w_baud_clk(clk), .i_rst(rst), .i_valid(valid_b), .i_data(data_b),
      .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_count(count_b)
   );

   // Free-running bit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // One frame as it appears on the line, derived from the frame format rules.
   function automatic void buildFrame(input logic [7:0] b);
      bit par;
      par = (($countones(b) % 2) == 1) ? (m_odd == 0) : (m_odd != 0);
      lq.push_back(1'b0);
      for (int i = 0; i < 8; i++) lq.push_back(b[i]);
      lq.push_back(par);
      lq.push_back(1'b1);
      lq.push_back(1'b1);
      for (int i = 0; i < m_gap; i++) lq.push_back(1'b1);
   endfunction

   // Drive one cycle of input, advance the model and check the outputs after the edge.
   task automatic applyStimulus(input bit v, input logic [7:0] d);
      bit exp_ready, exp_tx, exp_busy;
      if (sel) begin
         valid_b = v; data_b = d; valid_a = 1'b0;
      end else begin
         valid_a = v; data_a = d; valid_b = 1'b0;
      end
      #1;
      exp_ready = (mq.size() != DEPTH);
      checkOutput("ready", sel ? ready_b : ready_a, exp_ready);
      if (lq.size() == 0 && mq.size() > 0) buildFrame(mq.pop_front());
      last_push = v && exp_ready;
      if (last_push) mq.push_back(d);
      if (lq.size() > 0) begin
         exp_tx = lq.pop_front();
         exp_busy = 1'b1;
      end else begin
         exp_tx = 1'b1;
         exp_busy = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("tx", sel ? tx_b : tx_a, exp_tx);
      checkOutput("busy", sel ? busy_b : busy_a, exp_busy);
      checkOutput("count", sel ? count_b : count_a, mq.size());
      cap = {cap[10:0], (sel ? tx_b : tx_a)};
   endtask

   task automatic doReset();
      rst = 1'b0;
      valid_a = 1'b0;
      valid_b = 1'b0;
      #1;
      checkOutput("rst_tx", sel ? tx_b : tx_a, 1);
      checkOutput("rst_busy", sel ? busy_b : busy_a, 0);
      checkOutput("rst_count", sel ? count_b : count_a, 0);
      checkOutput("rst_ready", sel ? ready_b : ready_a, 1);
      mq.delete();
      lq.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      while ((lq.size() > 0 || mq.size() > 0) && n < 400) begin
         applyStimulus(1'b0, 8'd0);
         n++;
      end
      checkOutput("drain_done", lq.size() + mq.size(), 0);
      applyStimulus(1'b0, 8'd0);
   endtask

   // Random producer that holds its offer until the framer accepts it.
   task automatic runRandom(input int n, input int pct);
      bit v = 1'b0;
      logic [7:0] d = 8'd0;
      for (int i = 0; i < n; i++) begin
         if (!(v && !last_push)) begin
            v = ($urandom_range(99) < pct);
            d = 8'($urandom);
         end
         applyStimulus(v, d);
      end
   endtask

   initial begin
      logic [7:0] burst [6];
      int idx;
      int guard;

      @(negedge clk);
      sel = 1'b0; m_odd = 0; m_gap = 0;
      doReset();

      // Single byte 0xA5: start, data LSB first, even parity, two stops.
      applyStimulus(1'b1, 8'hA5);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 8'd0);
      checkOutput("frame_a5", cap, 12'b010100101011);
      applyStimulus(1'b0, 8'd0);

      // Three bytes on consecutive edges go out back-to-back.
      applyStimulus(1'b1, 8'h01);
      applyStimulus(1'b1, 8'h02);
      applyStimulus(1'b1, 8'h03);
      drain();

      // Overfill: producer holds i_valid while the FIFO is full.
      for (int i = 0; i < 6; i++) burst[i] = 8'h10 + 8'(i * 17);
      idx = 0;
      guard = 0;
      while (idx < 6 && guard < 200) begin
         applyStimulus(1'b1, burst[idx]);
         if (last_push) idx++;
         guard++;
      end
      checkOutput("burst_accepted", idx, 6);
      drain();

      runRandom(600, 40);
      runRandom(300, 90);
      drain();

      // Reset in the middle of data bit 4 with another byte still buffered.
      applyStimulus(1'b1, 8'hE5);
      applyStimulus(1'b1, 8'h81);
      guard = 0;
      while (lq.size() != 6 && guard < 40) begin
         applyStimulus(1'b0, 8'd0);
         guard++;
      end
      checkOutput("at_bit4", lq.size(), 6);
      doReset();
      applyStimulus(1'b1, 8'h5A);
      drain();

      // Odd parity with three idle gap bits between frames.
      sel = 1'b1; m_odd = 1; m_gap = 3;
      doReset();
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'hFF);
      drain();
      runRandom(400, 60);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
